// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: multi-channel RGB LED PWM driver with off, steady, blink and breathe modes
module rgb_pwm_ctrl #(
  parameter int N_CH        = 2,
  parameter int PWM_PERIOD  = 100,
  parameter int DUTY_W      = 7,
  parameter int TICK_DIV    = 1000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          flag,
  input  logic [2*N_CH-1:0]        mode,
  input  logic [N_CH*DUTY_W-1:0]   duty_r,
  input  logic [N_CH*DUTY_W-1:0]   duty_g,
  input  logic [N_CH*DUTY_W-1:0]   duty_b,
  output logic [N_CH-1:0]          led_r,
  output logic [N_CH-1:0]          led_g,
  output logic [N_CH-1:0]          led_b
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  localparam logic [DUTY_W-1:0] CNT_MAX   = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [TW-1:0]     TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0]     BLINK_MAX = BW'(BLINK_TICKS - 1);
  typedef enum logic {RISE, FALL} env_state_e;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic phase_q, phase_d;
  logic [7:0] env_q, env_d;
  env_state_e state_q, state_d;
  logic tick, blink_wrap, turn, reload;
  logic [2:0][N_CH-1:0][DUTY_W-1:0] duty_in, tgt, shd_q, shd_d;
  logic [2:0][N_CH-1:0] led_q, led_d;
  assign duty_in = {duty_b, duty_g, duty_r};
  assign {led_b, led_g, led_r} = led_q;
  // Breathe scaling keeps the full duty*envelope product before dropping the 8 fraction bits.
  function automatic logic [DUTY_W-1:0] scale(input logic [DUTY_W-1:0] d, input logic [7:0] e);
    logic [DUTY_W+7:0] p;
    p = {8'd0, d} * {{DUTY_W{1'b0}}, e};
    return p[DUTY_W+7:8];
  endfunction
  // Shared timebase: period counter, tick divider and blink phase, common to every channel.
  always_comb begin
    reload      = cnt_q == CNT_MAX;
    cnt_d       = reload ? '0 : cnt_q + 1'b1;
    tick        = tick_cnt_q == TICK_MAX;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    blink_wrap  = tick && blink_cnt_q == BLINK_MAX;
    blink_cnt_d = !tick ? blink_cnt_q : blink_wrap ? '0 : blink_cnt_q + 1'b1;
    phase_d     = phase_q ^ blink_wrap;
  end
  // Breathe envelope FSM: the turning tick holds the end value instead of stepping.
  always_comb begin
    turn    = tick && (state_q == RISE ? env_q == 8'hff : env_q == 8'h00);
    state_d = turn ? (state_q == RISE ? FALL : RISE) : state_q;
    env_d   = !tick || turn ? env_q : state_q == RISE ? env_q + 1'b1 : env_q - 1'b1;
  end
  // Per-colour target duty, shadow reload at period end, and gated PWM compare.
  always_comb begin
    tgt   = '0;
    shd_d = shd_q;
    led_d = '0;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < N_CH; i++) begin
        tgt[c][i]   = mode[2*i +: 2] == 2'b01 ? duty_in[c][i] :
                      mode[2*i +: 2] == 2'b10 ? (phase_q ? duty_in[c][i] : '0) :
                      mode[2*i +: 2] == 2'b11 ? scale(duty_in[c][i], env_q) : '0;
        shd_d[c][i] = reload ? tgt[c][i] : shd_q[c][i];
        led_d[c][i] = flag[i] && cnt_q < shd_q[c][i];
      end
  end
  // State registers; reset clears everything except the blink phase, which restarts on.
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q       <= '0;
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      env_q       <= '0;
      state_q     <= RISE;
      shd_q       <= '0;
      led_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      env_q       <= env_d;
      state_q     <= state_d;
      shd_q       <= shd_d;
      led_q       <= led_d;
    end
endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb_rgb_pwm_ctrl: scoreboard bench comparing each 100-cycle PWM window against queued patterns
module tb_rgb_pwm_ctrl;
  localparam int P = 100;
  localparam logic [99:0] Z = '0;
  localparam logic [99:0] F = '1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] flag = '0;
  logic [3:0] mode = '0;
  logic [13:0] duty_r = '0, duty_g = '0, duty_b = '0;
  logic [1:0] led_r, led_g, led_b;
  int t = 0;
  int rc = 0;
  int tests = 0;
  int fails = 0;
  int pos;
  logic done = 1'b0;
  logic [5:0] s;
  logic [5:0][99:0] acc = '0;
  logic [5:0][99:0] e;
  logic [5:0][99:0] exp_q[$];
  string names[6] = '{"r0", "g0", "b0", "r1", "g1", "b1"};
  string tag = "init";
  int bw[12] = '{0, 9, 19, 28, 38, 48, 58, 67, 77, 87, 97, 92};

  rgb_pwm_ctrl #(.N_CH(2), .PWM_PERIOD(100), .DUTY_W(7), .TICK_DIV(4), .BLINK_TICKS(25)) dut (
    .clk(clk), .rst(rst), .flag(flag), .mode(mode),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  always #5 clk = ~clk;

  // t counts edges since reset release, so t mod 100 equals the DUT period counter value
  always @(posedge clk) begin
    t  <= rst ? 0 : t + 1;
    rc <= rst ? rc + 1 : 0;
  end

  // monitor: sample at negedge, build per-window bit patterns, compare against the queue
  always @(negedge clk) begin
    s = {led_b[1], led_g[1], led_r[1], led_b[0], led_g[0], led_r[0]};
    if (done) begin
      tests++;
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL leftover_windows: got %0d unchecked, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
    if (rst && rc == 1) begin
      tests++;
      if (s !== 6'b0) begin
        fails++;
        $display("FAIL %s reset_leds: got %b want 000000", tag, s);
      end
    end
    if (!rst && t >= 1) begin
      pos = (t - 1) % P;
      for (int j = 0; j < 6; j++) acc[j][pos] = s[j];
      if (pos == P - 1) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL %s window %0d: got a window, want none queued", tag, (t - 1) / P);
        end else begin
          e = exp_q.pop_front();
          for (int j = 0; j < 6; j++) begin
            tests++;
            if (acc[j] !== e[j]) begin
              fails++;
              $display("FAIL %s w%0d %s: got %h want %h", tag, (t - 1) / P, names[j], acc[j], e[j]);
            end
          end
        end
      end
    end
  end

  function automatic logic [99:0] rng(int a, int b);
    logic [99:0] v = '0;
    for (int k = a; k < b; k++) v[k] = 1'b1;
    return v;
  endfunction

  task automatic push(input logic [99:0] r0, g0, b0, r1, g1, b1);
    exp_q.push_back({b1, g1, r1, b0, g0, r0});
  endtask

  task automatic set(input logic [1:0] fl, input logic [3:0] md,
                     input logic [6:0] r0, g0, b0, r1, g1, b1);
    flag = fl;
    mode = md;
    duty_r = {r1, r0};
    duty_g = {g1, g0};
    duty_b = {b1, b0};
  endtask

  task automatic wait_t(input int n);
    while (t < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #2;
    rst = 1'b1;
    tag = name;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("steady");
    set(2'b01, 4'b0101, 20, 0, 10, 50, 50, 50);
    push(Z, Z, Z, Z, Z, Z);
    push(rng(0, 20), Z, rng(0, 10), Z, Z, Z);
    push(rng(0, 50), Z, rng(0, 10), Z, Z, Z);
    push(rng(0, 50), Z, rng(0, 10), Z, Z, Z);
    wait_t(140);
    duty_r[6:0] = 7'd50;
    wait_t(401);

    do_reset("clamp");
    set(2'b01, 4'b0101, 127, 0, 0, 0, 0, 0);
    push(Z, Z, Z, Z, Z, Z);
    push(F, Z, Z, Z, Z, Z);
    push(F, Z, Z, Z, Z, Z);
    push(Z, Z, Z, Z, Z, Z);
    wait_t(250);
    duty_r[6:0] = 7'd0;
    wait_t(401);

    do_reset("flag");
    set(2'b01, 4'b0101, 20, 0, 0, 0, 0, 0);
    push(Z, Z, Z, Z, Z, Z);
    push(rng(0, 5) | rng(10, 20), Z, Z, Z, Z, Z);
    push(rng(0, 20), Z, Z, Z, Z, Z);
    wait_t(105);
    flag[0] = 1'b0;
    wait_t(110);
    flag[0] = 1'b1;
    wait_t(301);

    do_reset("blink");
    set(2'b11, 4'b0010, 30, 0, 0, 50, 50, 50);
    push(Z, Z, Z, Z, Z, Z);
    push(rng(0, 30), Z, Z, Z, Z, Z);
    push(Z, Z, Z, Z, Z, Z);
    push(rng(0, 30), Z, Z, Z, Z, Z);
    push(Z, Z, Z, Z, Z, Z);
    wait_t(501);

    do_reset("breathe");
    set(2'b11, 4'b0111, 100, 0, 0, 127, 0, 0);
    for (int w = 0; w < 6; w++) push(rng(0, bw[w]), Z, Z, w == 0 ? Z : F, Z, Z);
    wait_t(650);

    do_reset("breathe_rerun");
    for (int w = 0; w < 12; w++) push(rng(0, bw[w]), Z, Z, w == 0 ? Z : F, Z, Z);
    wait_t(1201);

    done = 1'b1;
  end
endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
- REQ-001: Parameter N_CH, default 2: number of RGB LED channels.
- REQ-002: Parameter PWM_PERIOD, default 100: PWM period in clk cycles (2 to 2^DUTY_W).
- REQ-003: Parameter DUTY_W, default 7: width of each colour duty value.
- REQ-004: Parameter TICK_DIV, default 1000: clk cycles per timebase tick.
- REQ-005: Parameter BLINK_TICKS, default 250: ticks per blink half-phase.
- REQ-006: clk  input  1  single system clock; all logic on its rising edge.
- REQ-007: rst  input  1  synchronous, active-high reset.
- REQ-008: flag  input  N_CH  per-channel enable; bit i low forces channel i dark.
- REQ-009: mode  input  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 steady, 10 blink, 11 breathe.
- REQ-010: duty_r, duty_g, duty_b  input  N_CH*DUTY_W each  per-channel colour duty, channel i at bits [DUTY_W*i +: DUTY_W].
- REQ-011: led_r, led_g, led_b  output  N_CH each  registered PWM drive, bit i = channel i.

Function
- REQ-012: Period counter SHALL count 0..PWM_PERIOD-1 and wrap to 0; it is shared by all channels.
- REQ-013: Tick counter SHALL count 0..TICK_DIV-1; it SHALL assert a one-cycle tick on wrap.
- REQ-014: Blink phase bit SHALL toggle after every BLINK_TICKS ticks; 1 = on.
- REQ-015: Breathe envelope SHALL be 8 bits, with FSM states RISE and FALL.
- REQ-016: On each tick in RISE, the envelope SHALL increment; at 255 the FSM SHALL go to FALL, holding 255 on that tick.
- REQ-017: On each tick in FALL, the envelope SHALL decrement; at 0 the FSM SHALL go to RISE, holding 0 on that tick.
- REQ-018: Target duty per colour SHALL be:
  - off: 0
  - steady: duty
  - blink: duty while phase=1, else 0
  - breathe: (duty*envelope)>>8, computed full width with no overflow.
- REQ-019: Each channel/colour SHALL hold a shadow duty register, loaded from the target only in the cycle where the counter = PWM_PERIOD-1; mode/duty changes mid-period take effect at the next period start.
- REQ-020: Output next-state SHALL be flag[i] AND (counter < shadow duty); the output register updates every cycle, giving 1 cycle latency from counter to pin.
- REQ-021: Shadow duty >= PWM_PERIOD SHALL give constant high (no dropout at wrap); shadow 0 SHALL give constant low.
- REQ-022: Flag gating SHALL NOT be shadowed; a flag falling edge darkens the pin the next cycle, and a rising edge resumes with the current shadow.
- REQ-023: All channels SHALL share the counter, tick, blink phase and envelope, so channels remain phase-aligned.
- REQ-024: The block SHALL contain no latches; every output and register is defined in every cycle.

Reset
- REQ-025: While rst=1, the following SHALL be held on the next edge and maintained while rst stays high:
  - period counter, tick counter and envelope = 0
  - blink phase = 1
  - FSM = RISE
  - all shadow duties = 0
  - all led_* = 0
- REQ-026: A reset asserted mid-period, mid-blink or mid-breathe SHALL abort immediately with no residual state.
- REQ-027: After release, the first period SHALL output low, because shadows are 0 until the first reload.

Verification
- REQ-028: Steady, ch0 flag=1, mode=01, r=20 g=0 b=10, defaults -> from the 2nd period: led_r[0] high 20 of every 100 cycles, led_b[0] high 10, led_g[0] always 0; ch1 flag=0 -> all 0.
- REQ-029: Steady r=20; change r to 50 at counter=40 -> remainder of that period still shows 20; next period high for 50 cycles.
- REQ-030: Duty clamp, r=127 then r=0 -> led_r constant 1 across wrap for the full period; then constant 0.
- REQ-031: Blink with TICK_DIV=4, BLINK_TICKS=25, PWM_PERIOD=100, r=30 -> alternating 100-cycle windows: one with a 30-cycle pulse, one fully dark; aligned to period start.
- REQ-032: Breathe with TICK_DIV=1, r=100 -> shadow follows (100*env)>>8, rising to 99 then falling to 0; FSM turn at env=255 and env=0, with envelope period 512 ticks.
- REQ-033: Flag drop at counter=5 with r=20 -> led_r low on the following cycle; rst=1 at breathe env=100 -> next cycle all outputs 0, env 0, state RISE, phase 1.
